// File: rtl/fetch_stage_if.sv
// Interface bundling the fetch stage's instruction-ROM port, redirect input,
// decode handshake and status outputs. The fetch stage uses the master
// modport; the environment (ROM, branch unit, decode) uses the slave modport.
interface fetch_stage_if;
  // Instruction ROM port (combinational read).
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  // Branch / exception redirect.
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // Decode handshake.
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  // Status and performance counters.
  logic        fault;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output dec_valid,
    output dec_instr,
    output dec_pc,
    input  dec_ready,
    output fault,
    output perf_fetch_cnt,
    output perf_stall_cnt
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  dec_valid,
    input  dec_instr,
    input  dec_pc,
    output dec_ready,
    input  fault,
    input  perf_fetch_cnt,
    input  perf_stall_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Drives the fetch PC to a combinational instruction
// ROM, captures {pc, instr} into a small prefetch FIFO and presents the FIFO
// head to decode over valid/ready. A redirect flushes the FIFO and restarts
// fetch at the word-aligned target; a misaligned target sets a sticky fault.
// Optional feature macro: FETCH_PERF_EN enables the saturating fetch/stall
// performance counters; without it both counter outputs are tied to zero.
// FIFO_DEPTH must be a power of two in the range 2..8.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master bus
);

  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   r_fpc;
  logic [31:0]   r_instr_q [FIFO_DEPTH];
  logic [31:0]   r_pc_q    [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_fault;

  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_target;

  assign w_full   = (r_count == FULL_CNT);
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & bus.dec_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still sustains one
  // instruction per cycle when decode is draining it.
  assign w_push   = ~bus.redirect_valid & (~w_full | w_pop);
  assign w_target = {bus.redirect_pc[31:2], 2'b00};

  assign bus.imem_addr = r_fpc;
  assign bus.dec_valid = w_valid;
  // Decode sees FIFO storage only; there is no path from imem_rd to dec_*.
  assign bus.dec_instr = r_instr_q[r_rd_ptr];
  assign bus.dec_pc    = r_pc_q[r_rd_ptr];
  assign bus.fault     = r_fault;

  // Fetch PC, FIFO pointers/count and the sticky misalignment fault.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fpc    <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
        r_fault <= 1'b1;
      end
      if (bus.redirect_valid) begin
        // Any head popped this cycle is consumed; everything else is dropped.
        r_fpc    <= w_target;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_fpc    <= r_fpc + 32'd4;
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // FIFO storage: capture {pc, instr} at the write pointer on every push.
  // NOTE: the storage is reset because dec_instr/dec_pc read it directly and
  // must be zero out of reset; at 2..8 entries this is cheap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc_q[i]    <= '0;
      end
    end else if (w_push) begin
      r_instr_q[r_wr_ptr] <= bus.imem_rd;
      r_pc_q[r_wr_ptr]    <= r_fpc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = ~bus.redirect_valid & w_full & ~w_pop;

  // Saturating counters of pushes and of cycles blocked by a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push && (r_perf_fetch != 32'hFFFF_FFFF)) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign bus.perf_fetch_cnt = r_perf_fetch;
  assign bus.perf_stall_cnt = r_perf_stall;
`else
  assign bus.perf_fetch_cnt = 32'h0;
  assign bus.perf_stall_cnt = 32'h0;
`endif

endmodule
